// File: rtl/voice_bank_pkg.sv
// Shared types and helpers for the polyphonic voice bank.
package voice_bank_pkg;

  // Waveform select codes carried on cmd_wave.
  typedef enum logic [1:0] {
    WAVE_SAW    = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SILENT = 2'd3
  } wave_e;

  // Per-voice envelope state.
  typedef enum logic [1:0] {
    ENV_IDLE    = 2'd0,
    ENV_ATTACK  = 2'd1,
    ENV_SUSTAIN = 2'd2,
    ENV_RELEASE = 2'd3
  } env_state_e;

  // Frame sequencer state.
  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_e;

  localparam int unsigned SAT_W = 64;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [SAT_W-1:0] sat_s64(input logic signed [SAT_W-1:0] x,
                                                      input int unsigned w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/voice_env_step.sv
// One frame of the linear attack/sustain/release envelope for a single voice.
module voice_env_step
  import voice_bank_pkg::*;
#(
  parameter int unsigned ENV_W = 18
) (
  input  env_state_e       i_state,
  input  logic [ENV_W-1:0] i_env,
  input  logic [ENV_W-1:0] i_atk_step,
  input  logic [ENV_W-1:0] i_rel_step,
  output env_state_e       o_state_c,
  output logic [ENV_W-1:0] o_env_c,
  output logic             o_done_c
);

  localparam logic [ENV_W-1:0] ENV_MAX = '1;

  logic [ENV_W:0] w_sum;

  // Next envelope level/state; attack saturates at full scale, release floors at zero.
  always_comb begin
    o_state_c = i_state;
    o_env_c   = i_env;
    o_done_c  = 1'b0;
    w_sum     = {1'b0, i_env} + {1'b0, i_atk_step};
    case (i_state)
      ENV_ATTACK: begin
        if (w_sum >= {1'b0, ENV_MAX}) begin
          o_env_c   = ENV_MAX;
          o_state_c = ENV_SUSTAIN;
        end else begin
          o_env_c = w_sum[ENV_W-1:0];
        end
      end
      ENV_SUSTAIN: o_env_c = i_env;
      ENV_RELEASE: begin
        if (i_env <= i_rel_step) begin
          o_env_c   = '0;
          o_state_c = ENV_IDLE;
          o_done_c  = 1'b1;
        end else begin
          o_env_c = i_env - i_rel_step;
        end
      end
      default: o_env_c = '0;
    endcase
  end

endmodule

// File: rtl/voice_bank.sv
// N-voice polyphonic synth: one shared datapath steps one voice per clock after each tick.
module voice_bank
  import voice_bank_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned PHASE_W    = 32,
  parameter int unsigned SAMPLE_W   = 24,
  parameter int unsigned ENV_W      = 18
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic                          sample_tick,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [$clog2(NUM_VOICES)-1:0] cmd_voice,
  input  logic                          cmd_on,
  input  logic [1:0]                    cmd_wave,
  input  logic [PHASE_W-1:0]            cmd_inc,
  input  logic [ENV_W-1:0]              atk_step,
  input  logic [ENV_W-1:0]              rel_step,
  output logic [SAMPLE_W-1:0]           audio_out,
  output logic                          audio_valid,
  output logic [NUM_VOICES-1:0]         voice_active,
  output logic [NUM_VOICES-1:0]         voice_done,
  output logic                          overrun
);

  localparam int unsigned VIDX_W = $clog2(NUM_VOICES);
  localparam int unsigned ACC_W  = SAMPLE_W + VIDX_W;
  localparam int unsigned PROD_W = SAMPLE_W + ENV_W + 1;
  localparam logic [VIDX_W-1:0]     LAST_IDX = VIDX_W'(NUM_VOICES - 1);
  localparam logic [NUM_VOICES-1:0] ONE_HOT0 = NUM_VOICES'(1);
  localparam logic signed [SAMPLE_W-1:0] SQ_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SAMPLE_W-1:0] SQ_NEG = {1'b1, {(SAMPLE_W-2){1'b0}}, 1'b1};

  // Voice register file, indexed by the sequencer.
  logic [PHASE_W-1:0] r_phase [NUM_VOICES];
  logic [PHASE_W-1:0] r_inc   [NUM_VOICES];
  wave_e              r_wave  [NUM_VOICES];
  logic [ENV_W-1:0]   r_env   [NUM_VOICES];
  env_state_e         r_state [NUM_VOICES];

  seq_state_e               r_seq_state;
  seq_state_e               w_seq_next;
  logic [VIDX_W-1:0]        r_idx;
  logic signed [ACC_W-1:0]  r_acc;
  logic [NUM_VOICES-1:0]    r_done_pend;

  logic w_frame_start;
  logic w_frame_last;
  logic w_overrun_hit;
  logic w_cmd_acc;

  logic [PHASE_W-1:0]         w_cur_phase;
  wave_e                      w_cur_wave;
  logic [SAMPLE_W-1:0]        w_p;
  logic [SAMPLE_W-2:0]        w_fold;
  logic signed [SAMPLE_W-1:0] w_tone;
  env_state_e                 w_state_next;
  logic [ENV_W-1:0]           w_env_next;
  logic                       w_env_done;
  logic signed [ENV_W:0]      w_env_s;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [PROD_W-1:0]   w_shift;
  logic signed [SAMPLE_W-1:0] w_contrib;
  logic signed [ACC_W-1:0]    w_acc_sum;
  logic [SAMPLE_W-1:0]        w_sat;
  logic [NUM_VOICES-1:0]      w_done_bit;

  assign cmd_ready   = (r_seq_state == SEQ_IDLE);
  assign w_cmd_acc   = cmd_valid && cmd_ready;
  assign w_cur_phase = r_phase[r_idx];
  assign w_cur_wave  = r_wave[r_idx];

  // Sequencer next state: a tick starts a frame, the last voice ends it, ticks mid-frame flag overrun.
  always_comb begin
    w_seq_next    = r_seq_state;
    w_frame_start = 1'b0;
    w_frame_last  = 1'b0;
    w_overrun_hit = 1'b0;
    case (r_seq_state)
      SEQ_IDLE: begin
        if (sample_tick) begin
          w_seq_next    = SEQ_RUN;
          w_frame_start = 1'b1;
        end
      end
      SEQ_RUN: begin
        w_overrun_hit = sample_tick;
        if (r_idx == LAST_IDX) begin
          w_seq_next   = SEQ_IDLE;
          w_frame_last = 1'b1;
        end
      end
      default: w_seq_next = SEQ_IDLE;
    endcase
  end

  voice_env_step #(
    .ENV_W(ENV_W)
  ) u_env_step (
    .i_state   (r_state[r_idx]),
    .i_env     (r_env[r_idx]),
    .i_atk_step(atk_step),
    .i_rel_step(rel_step),
    .o_state_c (w_state_next),
    .o_env_c   (w_env_next),
    .o_done_c  (w_env_done)
  );

  // Tone from the top phase bits, sampled before this frame's increment.
  always_comb begin
    w_p    = w_cur_phase[PHASE_W-1 -: SAMPLE_W];
    w_fold = w_p[SAMPLE_W-1] ? ~w_p[SAMPLE_W-2:0] : w_p[SAMPLE_W-2:0];
    case (w_cur_wave)
      WAVE_SAW:    w_tone = {~w_p[SAMPLE_W-1], w_p[SAMPLE_W-2:0]};
      WAVE_SQUARE: w_tone = w_p[SAMPLE_W-1] ? SQ_NEG : SQ_POS;
      WAVE_TRI:    w_tone = {~w_fold[SAMPLE_W-2], w_fold[SAMPLE_W-3:0], 1'b0};
      default:     w_tone = '0;
    endcase
  end

  // Scale tone by the updated envelope and fold into the running frame sum.
  always_comb begin
    w_env_s    = $signed({1'b0, w_env_next});
    w_prod     = PROD_W'(w_tone) * PROD_W'(w_env_s);
    w_shift    = w_prod >>> ENV_W;
    w_contrib  = SAMPLE_W'(w_shift);
    w_acc_sum  = r_acc + ACC_W'(w_contrib);
    w_sat      = SAMPLE_W'(sat_s64(SAT_W'(w_acc_sum), SAMPLE_W));
    w_done_bit = w_env_done ? (ONE_HOT0 << r_idx) : '0;
  end

  // Voice file updates: commands only while idle, per-voice step while running.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        r_phase[i] <= '0;
        r_inc[i]   <= '0;
        r_wave[i]  <= WAVE_SAW;
        r_env[i]   <= '0;
        r_state[i] <= ENV_IDLE;
      end
    end else begin
      if (w_cmd_acc) begin
        if (cmd_on) begin
          r_inc[cmd_voice]   <= cmd_inc;
          r_wave[cmd_voice]  <= wave_e'(cmd_wave);
          r_phase[cmd_voice] <= '0;
          r_state[cmd_voice] <= ENV_ATTACK;
        end else if ((r_state[cmd_voice] == ENV_ATTACK) || (r_state[cmd_voice] == ENV_SUSTAIN)) begin
          r_state[cmd_voice] <= ENV_RELEASE;
        end
      end
      if (r_seq_state == SEQ_RUN) begin
        r_env[r_idx]   <= w_env_next;
        r_state[r_idx] <= w_state_next;
        r_phase[r_idx] <= r_phase[r_idx] + r_inc[r_idx];
      end
    end
  end

  // Sequencer state, accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_seq_state <= SEQ_IDLE;
      r_idx       <= '0;
      r_acc       <= '0;
      r_done_pend <= '0;
      audio_out   <= '0;
      audio_valid <= 1'b0;
      voice_done  <= '0;
      overrun     <= 1'b0;
    end else begin
      r_seq_state <= w_seq_next;
      audio_valid <= 1'b0;
      voice_done  <= '0;
      if (w_overrun_hit) overrun <= 1'b1;
      if (w_frame_start) begin
        r_idx       <= '0;
        r_acc       <= '0;
        r_done_pend <= '0;
      end else if (r_seq_state == SEQ_RUN) begin
        r_acc       <= w_acc_sum;
        r_idx       <= r_idx + VIDX_W'(1);
        r_done_pend <= r_done_pend | w_done_bit;
        if (w_frame_last) begin
          audio_out   <= w_sat;
          audio_valid <= 1'b1;
          voice_done  <= r_done_pend | w_done_bit;
        end
      end
    end
  end

  // Activity flags follow the envelope state directly.
  always_comb begin
    voice_active = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      voice_active[i] = (r_state[i] != ENV_IDLE);
    end
  end

endmodule

// File: tb/tb_voice_bank.sv
// Directed self-checking bench for voice_bank.
module tb_voice_bank;

  localparam int unsigned NV = 8;
  localparam int unsigned PW = 32;
  localparam int unsigned SW = 24;
  localparam int unsigned EW = 18;
  localparam logic [EW-1:0] ENV_MAX = 18'h3FFFF;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          sample_tick;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_voice;
  logic          cmd_on;
  logic [1:0]    cmd_wave;
  logic [PW-1:0] cmd_inc;
  logic [EW-1:0] atk_step;
  logic [EW-1:0] rel_step;
  logic [SW-1:0] audio_out;
  logic          audio_valid;
  logic [NV-1:0] voice_active;
  logic [NV-1:0] voice_done;
  logic          overrun;

  int checks = 0;
  int failures = 0;
  logic [NV-1:0] done_cap;
  logic          ready_cap;

  voice_bank #(.NUM_VOICES(NV), .PHASE_W(PW), .SAMPLE_W(SW), .ENV_W(EW)) dut (
    .clk(clk), .rst_b(rst_b), .sample_tick(sample_tick), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_voice(cmd_voice), .cmd_on(cmd_on), .cmd_wave(cmd_wave),
    .cmd_inc(cmd_inc), .atk_step(atk_step), .rel_step(rel_step), .audio_out(audio_out),
    .audio_valid(audio_valid), .voice_active(voice_active), .voice_done(voice_done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_b = 1'b0; sample_tick = 1'b0; cmd_valid = 1'b0; cmd_voice = '0; cmd_on = 1'b0;
    cmd_wave = '0; cmd_inc = '0; atk_step = '0; rel_step = '0;
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input int v, input logic on, input logic [1:0] wave, input logic [PW-1:0] inc);
    cmd_valid = 1'b1; cmd_voice = 3'(v); cmd_on = on; cmd_wave = wave; cmd_inc = inc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Pulse a tick and wait (bounded) for audio_valid; lat counts cycles after the tick.
  task automatic do_frame(output int lat);
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    ready_cap = cmd_ready;
    lat = 1;
    while (audio_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    done_cap = voice_done;
  endtask

  task automatic test_reset();
    rst_b = 1'b0; sample_tick = 1'b0; cmd_valid = 1'b0; cmd_voice = '0; cmd_on = 1'b0;
    cmd_wave = '0; cmd_inc = '0; atk_step = '0; rel_step = '0;
    repeat (2) @(posedge clk); #1;
    checks++; if (audio_out !== 24'h0) begin failures++; $display("FAIL rst_audio got=%h exp=0", audio_out); end
    checks++; if (audio_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", audio_valid); end
    checks++; if (voice_active !== 8'h00) begin failures++; $display("FAIL rst_active got=%h exp=00", voice_active); end
    checks++; if (voice_done !== 8'h00) begin failures++; $display("FAIL rst_done got=%h exp=00", voice_done); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rst_overrun got=%b exp=0", overrun); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", cmd_ready); end
    #1 rst_b = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_square();
    int lat;
    apply_reset();
    atk_step = ENV_MAX;
    send_cmd(0, 1'b1, 2'd1, 32'h1000_0000);
    do_frame(lat);
    checks++; if (lat !== 9) begin failures++; $display("FAIL sq_latency got=%0d exp=9", lat); end
    checks++; if (audio_out !== 24'h7FFFDF) begin failures++; $display("FAIL sq_audio got=%h exp=7fffdf", audio_out); end
    checks++; if (voice_active !== 8'h01) begin failures++; $display("FAIL sq_active got=%h exp=01", voice_active); end
    checks++; if (ready_cap !== 1'b0) begin failures++; $display("FAIL sq_busy_ready got=%b exp=0", ready_cap); end
    checks++; if (done_cap !== 8'h00) begin failures++; $display("FAIL sq_done got=%h exp=00", done_cap); end
    @(posedge clk); #1;
    checks++; if (audio_valid !== 1'b0) begin failures++; $display("FAIL sq_valid_pulse got=%b exp=0", audio_valid); end
    checks++; if (audio_out !== 24'h7FFFDF) begin failures++; $display("FAIL sq_hold got=%h exp=7fffdf", audio_out); end
  endtask

  task automatic test_saturate();
    int lat;
    logic [SW-1:0] exp_sat [3];
    exp_sat[0] = 24'h7FFFFF; exp_sat[1] = 24'h800000; exp_sat[2] = 24'h7FFFFF;
    apply_reset();
    atk_step = ENV_MAX;
    for (int v = 0; v < 8; v++) send_cmd(v, 1'b1, 2'd1, 32'h8000_0000);
    for (int f = 0; f < 3; f++) begin
      do_frame(lat);
      checks++; if (audio_out !== exp_sat[f]) begin failures++; $display("FAIL sat_f%0d got=%h exp=%h", f, audio_out, exp_sat[f]); end
    end
    checks++; if (voice_active !== 8'hFF) begin failures++; $display("FAIL sat_active got=%h exp=ff", voice_active); end
  endtask

  task automatic test_release();
    int lat;
    logic [SW-1:0] exp_rel [4];
    exp_rel[0] = 24'h5FFFDF; exp_rel[1] = 24'h3FFFDF; exp_rel[2] = 24'h1FFFDF; exp_rel[3] = 24'h000000;
    apply_reset();
    atk_step = ENV_MAX; rel_step = 18'h10000;
    send_cmd(0, 1'b1, 2'd1, 32'h0);
    do_frame(lat);
    send_cmd(0, 1'b0, 2'd0, 32'h0);
    for (int f = 0; f < 4; f++) begin
      do_frame(lat);
      checks++; if (audio_out !== exp_rel[f]) begin failures++; $display("FAIL rel_audio_f%0d got=%h exp=%h", f, audio_out, exp_rel[f]); end
      checks++; if (done_cap !== ((f == 3) ? 8'h01 : 8'h00)) begin failures++; $display("FAIL rel_done_f%0d got=%h", f, done_cap); end
      checks++; if (voice_active !== ((f == 3) ? 8'h00 : 8'h01)) begin failures++; $display("FAIL rel_active_f%0d got=%h", f, voice_active); end
    end
    do_frame(lat);
    checks++; if (audio_out !== 24'h0) begin failures++; $display("FAIL rel_after got=%h exp=0", audio_out); end
    checks++; if (done_cap !== 8'h00) begin failures++; $display("FAIL rel_after_done got=%h exp=00", done_cap); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_overrun();
    int lat;
    int nval = 0;
    int vcyc = 0;
    logic ov4 = 1'b0;
    apply_reset();
    atk_step = ENV_MAX;
    send_cmd(0, 1'b1, 2'd1, 32'h0);
    sample_tick = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      sample_tick = (c == 3);
      if (audio_valid === 1'b1) begin nval++; vcyc = c; end
      if (c == 4) ov4 = overrun;
    end
    checks++; if (nval !== 1) begin failures++; $display("FAIL ovr_nvalid got=%0d exp=1", nval); end
    checks++; if (vcyc !== 9) begin failures++; $display("FAIL ovr_valid_cycle got=%0d exp=9", vcyc); end
    checks++; if (ov4 !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", ov4); end
    do_frame(lat);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    checks++; if (audio_out !== 24'h7FFFDF) begin failures++; $display("FAIL ovr_audio got=%h exp=7fffdf", audio_out); end
  endtask

  task automatic test_retrigger();
    int lat;
    apply_reset();
    atk_step = 18'h10000; rel_step = 18'h10000;
    send_cmd(0, 1'b1, 2'd1, 32'h0);
    do_frame(lat);
    checks++; if (audio_out !== 24'h1FFFFF) begin failures++; $display("FAIL rtg_atk1 got=%h exp=1fffff", audio_out); end
    do_frame(lat);
    checks++; if (audio_out !== 24'h3FFFFF) begin failures++; $display("FAIL rtg_atk2 got=%h exp=3fffff", audio_out); end
    send_cmd(0, 1'b0, 2'd0, 32'h0);
    send_cmd(3, 1'b0, 2'd0, 32'h0);
    atk_step = 18'h8000;
    send_cmd(0, 1'b1, 2'd1, 32'h0);
    do_frame(lat);
    checks++; if (audio_out !== 24'h4FFFFF) begin failures++; $display("FAIL rtg_env got=%h exp=4fffff", audio_out); end
    checks++; if (voice_active !== 8'h01) begin failures++; $display("FAIL rtg_active got=%h exp=01", voice_active); end
    do_frame(lat);
    checks++; if (audio_out !== 24'h5FFFFF) begin failures++; $display("FAIL rtg_still_attack got=%h exp=5fffff", audio_out); end
  endtask

  task automatic test_waves();
    int lat;
    apply_reset();
    atk_step = ENV_MAX;
    send_cmd(0, 1'b1, 2'd0, 32'h4000_0000);
    do_frame(lat);
    checks++; if (audio_out !== 24'h800020) begin failures++; $display("FAIL saw_p0 got=%h exp=800020", audio_out); end
    do_frame(lat);
    checks++; if (audio_out !== 24'hC00010) begin failures++; $display("FAIL saw_q1 got=%h exp=c00010", audio_out); end
    send_cmd(0, 1'b1, 2'd2, 32'h4000_0000);
    do_frame(lat);
    checks++; if (audio_out !== 24'h800020) begin failures++; $display("FAIL tri_p0 got=%h exp=800020", audio_out); end
    do_frame(lat);
    checks++; if (audio_out !== 24'h000000) begin failures++; $display("FAIL tri_q1 got=%h exp=000000", audio_out); end
    do_frame(lat);
    checks++; if (audio_out !== 24'h7FFFDE) begin failures++; $display("FAIL tri_half got=%h exp=7fffde", audio_out); end
    send_cmd(0, 1'b1, 2'd3, 32'h0);
    do_frame(lat);
    checks++; if (audio_out !== 24'h000000) begin failures++; $display("FAIL silent got=%h exp=000000", audio_out); end
    checks++; if (voice_active !== 8'h01) begin failures++; $display("FAIL silent_active got=%h exp=01", voice_active); end
  endtask

  task automatic test_midframe_reset();
    int lat;
    int nval = 0;
    apply_reset();
    atk_step = ENV_MAX;
    send_cmd(0, 1'b1, 2'd1, 32'h0);
    do_frame(lat);
    checks++; if (audio_out !== 24'h7FFFDF) begin failures++; $display("FAIL mrst_pre got=%h exp=7fffdf", audio_out); end
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_b = 1'b0;
    #1;
    checks++; if (audio_out !== 24'h0) begin failures++; $display("FAIL mrst_audio got=%h exp=0", audio_out); end
    checks++; if (voice_active !== 8'h00) begin failures++; $display("FAIL mrst_active got=%h exp=00", voice_active); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL mrst_ready got=%b exp=1", cmd_ready); end
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (c == 2) rst_b = 1'b1;
      if (audio_valid === 1'b1) nval++;
    end
    checks++; if (nval !== 0) begin failures++; $display("FAIL mrst_novalid got=%0d exp=0", nval); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL mrst_overrun got=%b exp=0", overrun); end
  endtask

  initial begin
    test_reset();
    test_single_square();
    test_saturate();
    test_release();
    test_overrun();
    test_retrigger();
    test_waves();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
